// File: rtl/integrate_seq_ctrl.sv
// rtl/integrate_seq_ctrl.sv - table-driven delay/strobe/enable sequencer for the integrate block
module integrate_seq_ctrl #(
    parameter int DELAY_W = 34,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int DWELL_W = 16,
    parameter int GAP     = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Wr_En,
    input  logic [ADDR_W-1:0]  Wr_Addr,
    input  logic [DELAY_W-1:0] Wr_Delay,
    input  logic [DWELL_W-1:0] Wr_Dwell,
    input  logic [ADDR_W:0]    Num_Entries,
    input  logic [15:0]        Loop_Cnt,
    input  logic               Start,
    input  logic               Abort,
    output logic [DELAY_W-1:0] DelayV_Out,
    output logic               PSWR_Out,
    output logic               EN_Out,
    output logic               Busy,
    output logic               Done,
    output logic               Err,
    output logic [ADDR_W-1:0]  Entry_Idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STROBE,
        S_RUN,
        S_GAP
    } state_t;

    localparam logic [ADDR_W:0]    DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [DWELL_W-1:0] GAP_L   = DWELL_W'(GAP);
    localparam logic [DWELL_W-1:0] ONE_L   = DWELL_W'(1);

    state_t state, state_nxt;

    logic [DELAY_W-1:0] tbl_delay [DEPTH];
    logic [DWELL_W-1:0] tbl_dwell [DEPTH];

    logic [ADDR_W-1:0]  idx;
    logic [ADDR_W:0]    num_lat;
    logic [15:0]        loops_rem;
    logic               infinite;
    logic [DWELL_W-1:0] cnt;

    logic num_ok, start_ok, last_entry, more_loops, cnt_last;
    logic done_nxt, err_nxt;

    assign num_ok     = (Num_Entries != '0) && (Num_Entries <= DEPTH_L);
    assign start_ok   = (state == S_IDLE) && Start && !Abort && num_ok;
    assign last_entry = ({1'b0, idx} == (num_lat - 1'b1));
    assign more_loops = infinite || (loops_rem > 16'd1);
    assign cnt_last   = (cnt == ONE_L);

    assign PSWR_Out = (state == S_STROBE);
    assign EN_Out   = (state == S_RUN);
    assign Busy     = (state != S_IDLE);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if ((state != S_IDLE) && Wr_En) begin
            err_nxt = 1'b1;
        end
        if ((state == S_IDLE) && Start && !Abort && !num_ok) begin
            err_nxt = 1'b1;
        end
        if (Abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start_ok) state_nxt = S_LOAD;
                S_LOAD:   state_nxt = S_STROBE;
                S_STROBE: state_nxt = S_RUN;
                S_RUN:    if (cnt_last) state_nxt = S_GAP;
                S_GAP: begin
                    if (cnt_last) begin
                        if (!last_entry || more_loops) begin
                            state_nxt = S_LOAD;
                        end else begin
                            state_nxt = S_IDLE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Table, counters and registered outputs; reset also wipes the table.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_delay[i] <= '0;
                tbl_dwell[i] <= '0;
            end
            idx        <= '0;
            num_lat    <= '0;
            loops_rem  <= '0;
            infinite   <= 1'b0;
            cnt        <= '0;
            DelayV_Out <= '0;
            Entry_Idx  <= '0;
            Done       <= 1'b0;
            Err        <= 1'b0;
        end else begin
            Done <= done_nxt;
            Err  <= err_nxt;
            if ((state == S_IDLE) && Wr_En) begin
                tbl_delay[Wr_Addr] <= Wr_Delay;
                tbl_dwell[Wr_Addr] <= Wr_Dwell;
            end
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        num_lat   <= Num_Entries;
                        loops_rem <= Loop_Cnt;
                        infinite  <= (Loop_Cnt == 16'd0);
                        idx       <= '0;
                    end
                end
                S_LOAD: begin
                    DelayV_Out <= tbl_delay[idx];
                    Entry_Idx  <= idx;
                    cnt        <= (tbl_dwell[idx] == '0) ? ONE_L : tbl_dwell[idx];
                end
                S_RUN: begin
                    cnt <= cnt_last ? GAP_L : cnt - ONE_L;
                end
                S_GAP: begin
                    if (!cnt_last) begin
                        cnt <= cnt - ONE_L;
                    end else if (last_entry) begin
                        idx <= '0;
                        if (!infinite) loops_rem <= loops_rem - 16'd1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
